mem_resp_ctrl: RTL and testbench



---
 rtl/mem_resp_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_resp_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_resp_ctrl                                              |
// | Description : Memory-side responder for the load/store arbiter           |
// |               handshake. It accepts one read or write while enable_i is  |
// |               high and models a fixed-latency on-chip array. When the    |
// |               access completes it pulses done_o for one cycle. idle_o    |
// |               tells the arbiter that a new operation can be issued.      |
// | Option      : MEM_RESP_ERR_EN - when defined, an address with any bit    |
// |               above DEPTH_LOG2-1 set is out of range. Such an access     |
// |               raises err_o with done_o, its write is suppressed and its  |
// |               read returns 0. When undefined, err_o is 0 and the upper   |
// |               address bits alias.                                        |
// | Ports       : clk          system clock, rising edge                     |
// |               rst          asynchronous active-high reset                |
// |               enable_i     request from the arbiter, held until done     |
// |               rd_wrt_ca_i  1 = read, 0 = write (sampled with enable)     |
// |               addr_i       access address (sampled with enable)          |
// |               wdata_i      store data (sampled with enable)              |
// |               idle_o       a new operation can be accepted               |
// |               done_o       single-cycle completion pulse                 |
// |               rdata_o      read result, held until the next read         |
// |               err_o        address-range error, coincident with done_o   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_resp_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              rd_wrt_ca_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              idle_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
  // The counter holds the remaining BUSY cycles minus one, so the access
  // fires in the cycle where it reads zero.
  localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                w_oor;
  logic                w_mem_we;

  assign w_idx = addr_q[DEPTH_LOG2-1:0];

`ifdef MEM_RESP_ERR_EN
  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_oor
      assign w_oor = |addr_q[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate
`else
  // Upper address bits are ignored, so addresses alias onto the array.
  assign w_oor = 1'b0;
  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_alias
      logic w_unused_upper;
      assign w_unused_upper = ^addr_q[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset. A write fires only from the BUSY state, so an
  // asynchronous reset taken mid-operation cancels any pending write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    w_mem_we = 1'b0;
    idle_o   = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_o = 1'b1;
        if (enable_i) begin
          rd_d    = rd_wrt_ca_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = c_CNT_LOAD;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (!enable_i) begin
          // The arbiter withdrew the request, so abort without side effects.
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_DONE;
          err_d   = w_oor;
          if (rd_q) begin
            rdata_d = w_oor ? '0 : mem_q[w_idx];
          end else begin
            w_mem_we = !w_oor;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        idle_o  = 1'b1;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_resp_ctrl                                           |
// | Description : Randomised self-checking bench for mem_resp_ctrl. A plain  |
// |               array model predicts read data and err, and the latency    |
// |               and done-pulse timing are checked against fixed numbers.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_resp_ctrl;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 8;
  localparam int LATENCY    = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              rd_wrt_ca;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              idle;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: array contents, valid flags and the last read value
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_valid [DEPTH];
  logic [DATA_W-1:0] m_rdata;
  bit                m_rdata_known;

  mem_resp_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .rd_wrt_ca_i(rd_wrt_ca),
    .addr_i(addr), .wdata_i(wdata), .idle_o(idle), .done_o(done),
    .rdata_o(rdata), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  task automatic model_op(input bit rd, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output bit exp_err);
    int idx;
    exp_err = ERR_EN && ((a >> DEPTH_LOG2) != 0);
    idx     = int'(a) % DEPTH;
    if (rd) begin
      if (exp_err) begin
        m_rdata = '0; m_rdata_known = 1'b1;
      end else if (m_valid[idx]) begin
        m_rdata = m_mem[idx]; m_rdata_known = 1'b1;
      end else begin
        m_rdata_known = 1'b0;
      end
    end else if (!exp_err) begin
      m_mem[idx] = d; m_valid[idx] = 1'b1;
    end
  endtask

  // Issue one operation and measure its response. The operands are scrambled
  // during BUSY, and the request is dropped as soon as done is seen.
  task automatic run_op(input bit rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output int done_cyc, output int pulses, output logic [DATA_W-1:0] rv,
                        output logic ev, output bit idle_bad, output int done_at);
    @(negedge clk);
    enable = 1'b1; rd_wrt_ca = rd; addr = a; wdata = d;
    done_cyc = -1; pulses = 0; rv = '0; ev = 1'b0; idle_bad = 1'b0; done_at = -1;
    for (int c = 1; c <= LATENCY + 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        addr = ADDR_W'($urandom); wdata = DATA_W'($urandom); rd_wrt_ca = ~rd;
      end
      if (done) begin
        pulses++;
        if (!idle) idle_bad = 1'b1;
        if (done_cyc < 0) begin
          done_cyc = c; rv = rdata; ev = err; done_at = cyc; enable = 1'b0;
        end
      end else if (done_cyc < 0 && idle) begin
        idle_bad = 1'b1;
      end
      if (done_cyc >= 0 && c >= done_cyc + 1) break;
    end
    enable = 1'b0;
  endtask

  task automatic test_reset();
    int dc, np, da; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee;
    rst = 1'b1; enable = 1'b0; rd_wrt_ca = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if ({idle, done, err} !== 3'b100) begin errors++;
      $display("FAIL reset_flags: idle/done/err=%b required 100", {idle, done, err}); end
    checks++; if (rdata !== '0) begin errors++;
      $display("FAIL reset_rdata: got %h required 0000", rdata); end
    m_rdata = '0; m_rdata_known = 1'b1;
    model_op(1'b0, 16'h0020, 16'h00A5, ee);
    run_op(1'b0, 16'h0020, 16'h00A5, dc, np, rv, ev, ib, da);
    model_op(1'b1, 16'h0020, 16'h0000, ee);
    run_op(1'b1, 16'h0020, 16'h0000, dc, np, rv, ev, ib, da);
    // Assert reset mid-cycle, away from any clock edge.
    @(posedge clk); #3; rst = 1'b1; #1;
    checks++; if ({idle, done, err} !== 3'b100 || rdata !== '0) begin errors++;
      $display("FAIL reset_async: idle/done/err=%b rdata=%h required 100 0000", {idle, done, err}, rdata); end
    @(negedge clk); rst = 1'b0;
    m_rdata = '0; m_rdata_known = 1'b1;
  endtask

  task automatic test_write_read();
    int dc, np, da; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee;
    model_op(1'b0, 16'h0012, 16'hBEEF, ee);
    run_op(1'b0, 16'h0012, 16'hBEEF, dc, np, rv, ev, ib, da);
    checks++; if (dc !== LATENCY + 1 || np !== 1 || ib) begin errors++;
      $display("FAIL wr_timing: done cycle=%0d pulses=%0d idle_bad=%0d required %0d 1 0", dc, np, ib, LATENCY + 1); end
    model_op(1'b1, 16'h0012, 16'h0000, ee);
    run_op(1'b1, 16'h0012, 16'h0000, dc, np, rv, ev, ib, da);
    checks++; if (dc !== LATENCY + 1 || np !== 1 || ib) begin errors++;
      $display("FAIL rd_timing: done cycle=%0d pulses=%0d idle_bad=%0d required %0d 1 0", dc, np, ib, LATENCY + 1); end
    checks++; if (rv !== 16'hBEEF) begin errors++;
      $display("FAIL rd_data: got %h required BEEF", rv); end
    model_op(1'b0, 16'h0013, 16'h1234, ee);
    run_op(1'b0, 16'h0013, 16'h1234, dc, np, rv, ev, ib, da);
    checks++; if (rdata !== 16'hBEEF) begin errors++;
      $display("FAIL rd_hold: rdata after write=%h required BEEF", rdata); end
  endtask

  task automatic test_back_to_back();
    int dc, np, da1, da2, da3; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee;
    model_op(1'b0, 16'h0003, 16'h1111, ee);
    run_op(1'b0, 16'h0003, 16'h1111, dc, np, rv, ev, ib, da1);
    model_op(1'b0, 16'h0003, 16'h2222, ee);
    run_op(1'b0, 16'h0003, 16'h2222, dc, np, rv, ev, ib, da2);
    model_op(1'b1, 16'h0003, 16'h0000, ee);
    run_op(1'b1, 16'h0003, 16'h0000, dc, np, rv, ev, ib, da3);
    checks++; if (da2 - da1 !== LATENCY + 2 || da3 - da2 !== LATENCY + 2) begin errors++;
      $display("FAIL b2b_interval: intervals %0d %0d required %0d", da2 - da1, da3 - da2, LATENCY + 2); end
    checks++; if (rv !== 16'h2222 || np !== 1) begin errors++;
      $display("FAIL b2b_data: got %h pulses=%0d required 2222 1", rv, np); end
  endtask

  task automatic test_abort();
    int dc, np, da, seen; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee;
    model_op(1'b0, 16'h0004, 16'hAAAA, ee);
    run_op(1'b0, 16'h0004, 16'hAAAA, dc, np, rv, ev, ib, da);
    @(negedge clk);
    enable = 1'b1; rd_wrt_ca = 1'b0; addr = 16'h0004; wdata = 16'h5555;
    @(posedge clk); #1;           // BUSY cycle 1
    @(posedge clk); #1;           // BUSY cycle 2
    enable = 1'b0;
    seen = 0;
    for (int c = 0; c < LATENCY + 4; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0 || idle !== 1'b1) begin errors++;
      $display("FAIL abort_no_done: done pulses=%0d idle=%b required 0 1", seen, idle); end
    model_op(1'b1, 16'h0004, 16'h0000, ee);
    run_op(1'b1, 16'h0004, 16'h0000, dc, np, rv, ev, ib, da);
    checks++; if (rv !== 16'hAAAA) begin errors++;
      $display("FAIL abort_data: got %h required AAAA", rv); end
  endtask

  task automatic test_midop_reset();
    int dc, np, da; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee;
    model_op(1'b0, 16'h0008, 16'h0101, ee);
    run_op(1'b0, 16'h0008, 16'h0101, dc, np, rv, ev, ib, da);
    @(negedge clk);
    enable = 1'b1; rd_wrt_ca = 1'b0; addr = 16'h0008; wdata = 16'h7777;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++; if ({idle, done, err} !== 3'b100 || rdata !== '0) begin errors++;
      $display("FAIL midop_reset: idle/done/err=%b rdata=%h required 100 0000", {idle, done, err}, rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; enable = 1'b0;
    m_rdata = '0; m_rdata_known = 1'b1;
    model_op(1'b1, 16'h0008, 16'h0000, ee);
    run_op(1'b1, 16'h0008, 16'h0000, dc, np, rv, ev, ib, da);
    checks++; if (rv !== 16'h0101) begin errors++;
      $display("FAIL midop_data: got %h required 0101", rv); end
  endtask

  task automatic test_addr_range();
    int dc, np, da; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee;
    model_op(1'b0, 16'h0005, 16'h1234, ee);
    run_op(1'b0, 16'h0005, 16'h1234, dc, np, rv, ev, ib, da);
    model_op(1'b0, 16'h0105, 16'h9999, ee);
    run_op(1'b0, 16'h0105, 16'h9999, dc, np, rv, ev, ib, da);
    checks++; if (dc !== LATENCY + 1 || ev !== ERR_EN || np !== 1) begin errors++;
      $display("FAIL range_write: done cycle=%0d err=%b pulses=%0d required %0d %b 1", dc, ev, np, LATENCY + 1, ERR_EN); end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL range_err_clear: err after done=%b required 0", err); end
    model_op(1'b1, 16'h0005, 16'h0000, ee);
    run_op(1'b1, 16'h0005, 16'h0000, dc, np, rv, ev, ib, da);
    checks++; if (rv !== m_rdata || ev !== 1'b0) begin errors++;
      $display("FAIL range_index5: got %h err=%b required %h 0", rv, ev, m_rdata); end
    model_op(1'b1, 16'h0105, 16'h0000, ee);
    run_op(1'b1, 16'h0105, 16'h0000, dc, np, rv, ev, ib, da);
    checks++; if (rv !== m_rdata || ev !== ERR_EN) begin errors++;
      $display("FAIL range_read: got %h err=%b required %h %b", rv, ev, m_rdata, ERR_EN); end
  endtask

  task automatic test_random();
    int dc, np, da; logic [DATA_W-1:0] rv; logic ev; bit ib; bit ee; bit rd;
    logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;
    for (int n = 0; n < 60; n++) begin
      rd = ($urandom_range(0, 99) < 45);
      a  = ADDR_W'($urandom_range(0, 15) * 16 + 1);
      if ($urandom_range(0, 3) == 0) a[ADDR_W-1:DEPTH_LOG2] = (ADDR_W-DEPTH_LOG2)'($urandom_range(1, 255));
      d  = DATA_W'($urandom);
      model_op(rd, a, d, ee);
      run_op(rd, a, d, dc, np, rv, ev, ib, da);
      checks++; if (dc !== LATENCY + 1 || np !== 1 || ib || ev !== ee) begin errors++;
        $display("FAIL rand_resp[%0d]: done cycle=%0d pulses=%0d idle_bad=%0d err=%b required %0d 1 0 %b",
                 n, dc, np, ib, ev, LATENCY + 1, ee); end
      if (m_rdata_known) begin
        checks++; if (rdata !== m_rdata) begin errors++;
          $display("FAIL rand_rdata[%0d]: rd=%0d addr=%h got %h required %h", n, rd, a, rdata, m_rdata); end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_mem[i] = '0;
    end
    m_rdata = '0; m_rdata_known = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_midop_reset();
    test_addr_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
